// File: rtl/usrt_pkg.sv
// -----------------------------------------------------------------------------
// usrt_pkg
// Shared definitions for the USRT transmit path:
//   - parity_e   : line encodings of i_Parity (01 even, 10 odd, anything else none)
//   - state_e    : transmit FSM states
//   - tx_entry_t : one queued byte with its parity mode
//   - decode_parity / parity_bit : helpers for the framing logic
// -----------------------------------------------------------------------------
package usrt_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   typedef struct packed {
      logic [1:0]           parity;
      logic [DATA_BITS-1:0] data;
   } tx_entry_t;

   // 2'b11 is deliberately folded into "none" along with 2'b00.
   function automatic parity_e decode_parity(input logic [1:0] code);
      case (code)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

   // Even mode: bit makes the total count of ones even (XOR of data).
   // Odd mode: inverted. The result is ignored when mode is none.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                       input parity_e              mode);
      return (mode == PAR_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/usrt_tx_fifo.sv
// -----------------------------------------------------------------------------
// usrt_tx_fifo
// Synchronous FIFO holding queued transmit bytes with their parity mode.
// Only instantiated when USRT_TX_FIFO_EN is defined.
// Ports:
//   clk    in   system clock, posedge
//   rst    in   asynchronous reset, active-high; flushes the FIFO
//   push   in   write request; ignored while full
//   wdata  in   entry to write
//   pop    in   read request; ignored while empty
//   rdata  out  head entry (first-word fall-through, valid while !empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   level  out  occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module usrt_tx_fifo
   import usrt_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  tx_entry_t              wdata,
   input  logic                   pop,
   output tx_entry_t              rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   tx_entry_t     mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign level   = level_q;

   // NOTE: every signal assigned here gets its default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: storage is not reset; pointers and level alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/usrt_tx_ctrl.sv
// -----------------------------------------------------------------------------
// usrt_tx_ctrl
// USRT transmit controller. Frames each accepted byte as
//   start(0), 8 data bits LSB-first, optional parity, stop(1)
// and shifts it out on o_Tx with its own serial clock o_Sclk. Each bit lasts
// CLK_DIV i_Pclk cycles; o_Sclk is low for the first half of a bit and high
// for the second, so the far end samples on the rising edge (mid-bit).
// Build option:
//   USRT_TX_FIFO_EN undefined : single holding path, o_Ready only in IDLE,
//                                at least one IDLE cycle between frames.
//   USRT_TX_FIFO_EN defined   : FIFO_DEPTH-entry queue, o_Ready = ~full,
//                                queued frames go out back-to-back.
// Ports:
//   i_Pclk    in   system clock, posedge
//   i_Rst     in   asynchronous reset, active-high
//   i_Data    in   byte to send
//   i_Parity  in   01 even, 10 odd, 00/11 none; taken together with i_Data
//   i_Valid   in   i_Data/i_Parity valid
//   o_Ready   out  byte accepted when i_Valid & o_Ready
//   o_Tx      out  serial data, idles high
//   o_Sclk    out  serial clock, idles high
//   o_Busy    out  frame on the line
//   o_Done    out  one-cycle pulse on the last cycle of the stop bit
//   o_Level   out  FIFO occupancy (0 without USRT_TX_FIFO_EN)
// -----------------------------------------------------------------------------
module usrt_tx_ctrl
   import usrt_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        i_Pclk,
   input  logic                        i_Rst,
   input  logic [7:0]                  i_Data,
   input  logic [1:0]                  i_Parity,
   input  logic                        i_Valid,
   output logic                        o_Ready,
   output logic                        o_Tx,
   output logic                        o_Sclk,
   output logic                        o_Busy,
   output logic                        o_Done,
   output logic [$clog2(FIFO_DEPTH):0] o_Level
);

   localparam int             DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

   state_e                 state_q, state_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   has_par_q, has_par_d;
   logic                   par_bit_q, par_bit_d;

   // Source of the next frame: either the input port directly or the FIFO head.
   logic                   src_valid;
   tx_entry_t              src_entry;
   logic                   chain_ok;
   logic                   take;
   logic                   bit_end;
   parity_e                src_mode;

`ifdef USRT_TX_FIFO_EN
   tx_entry_t fifo_wdata;
   tx_entry_t fifo_rdata;
   logic      fifo_full;
   logic      fifo_empty;

   assign fifo_wdata = '{parity: i_Parity, data: i_Data};

   usrt_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_Pclk),
      .rst   (i_Rst),
      .push  (i_Valid),
      .wdata (fifo_wdata),
      .pop   (take),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (o_Level)
   );

   assign o_Ready   = ~fifo_full;
   assign src_valid = ~fifo_empty;
   assign src_entry = fifo_rdata;
   assign chain_ok  = 1'b1;
`else
   assign o_Ready   = (state_q == ST_IDLE);
   assign src_valid = i_Valid;
   assign src_entry = '{parity: i_Parity, data: i_Data};
   assign chain_ok  = 1'b0;
   assign o_Level   = '0;
`endif

   assign bit_end  = (div_q == DIV_LAST);
   assign src_mode = decode_parity(src_entry.parity);

   // A new frame loads from IDLE, or (queued build only) straight out of the
   // last stop-bit cycle so consecutive frames have no gap.
   assign take = src_valid &
                 ((state_q == ST_IDLE) | (chain_ok & (state_q == ST_STOP) & bit_end));

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      has_par_d = has_par_q;
      par_bit_d = par_bit_q;

      if (state_q != ST_IDLE) div_d = bit_end ? '0 : div_q + DIV_W'(1);

      case (state_q)
         ST_IDLE: ;
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == BIT_LAST) state_d = has_par_q ? ST_PARITY : ST_STOP;
               else                       bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         ST_PARITY: begin
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (bit_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Byte and mode are captured here so later input changes cannot
      // disturb the frame in flight.
      if (take) begin
         state_d   = ST_START;
         div_d     = '0;
         shift_d   = src_entry.data;
         has_par_d = (src_mode != PAR_NONE);
         par_bit_d = parity_bit(src_entry.data, src_mode);
      end
   end

   always_ff @(posedge i_Pclk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q   <= ST_IDLE;
         div_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         has_par_q <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         has_par_q <= has_par_d;
         par_bit_q <= par_bit_d;
      end
   end

   // Outputs decode registered state only, so o_Tx moves solely at bit boundaries.
   always_comb begin
      case (state_q)
         ST_START:  o_Tx = 1'b0;
         ST_DATA:   o_Tx = shift_q[0];
         ST_PARITY: o_Tx = par_bit_q;
         default:   o_Tx = 1'b1;
      endcase
   end

   assign o_Sclk = (state_q == ST_IDLE) | (div_q >= DIV_HALF);
   assign o_Busy = (state_q != ST_IDLE);
   assign o_Done = (state_q == ST_STOP) & bit_end;

endmodule

// File: tb/tb_usrt_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usrt_tx_ctrl
// Self-checking bench for usrt_tx_ctrl (CLK_DIV=4). Expected line waveforms
// come from a frame model that lists the bits of each frame from the byte and
// parity mode; every cycle of a frame is compared against that list, and the
// bits seen on o_Sclk rising edges are compared as a whole frame.
// Build option USRT_TX_FIFO_EN adds the queued back-to-back sequence.
// -----------------------------------------------------------------------------
module tb_usrt_tx_ctrl;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef USRT_TX_FIFO_EN
   localparam int START_LAT = 2;
`else
   localparam int START_LAT = 1;
`endif

   logic          i_Pclk = 1'b0;
   logic          i_Rst;
   logic [7:0]    i_Data;
   logic [1:0]    i_Parity;
   logic          i_Valid;
   logic          o_Ready;
   logic          o_Tx;
   logic          o_Sclk;
   logic          o_Busy;
   logic          o_Done;
   logic [LW-1:0] o_Level;

   int checks   = 0;
   int failures = 0;
   bit exp_bits[$];
   bit dec_bits[$];

   usrt_tx_ctrl #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .i_Pclk   (i_Pclk),
      .i_Rst    (i_Rst),
      .i_Data   (i_Data),
      .i_Parity (i_Parity),
      .i_Valid  (i_Valid),
      .o_Ready  (o_Ready),
      .o_Tx     (o_Tx),
      .o_Sclk   (o_Sclk),
      .o_Busy   (o_Busy),
      .o_Done   (o_Done),
      .o_Level  (o_Level)
   );

   always #5 i_Pclk = ~i_Pclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame model: start, data LSB-first, parity from the count of ones, stop.
   function automatic void build_expected(input logic [7:0] d, input logic [1:0] p);
      int ones;
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
      ones = $countones(d);
      if (p == 2'b01)      exp_bits.push_back(bit'(ones % 2));
      else if (p == 2'b10) exp_bits.push_back(bit'(1 - (ones % 2)));
      exp_bits.push_back(1'b1);
   endfunction

   function automatic logic [31:0] pack_bits(input bit q[$]);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
      return v;
   endfunction

   // Starts on the negedge of the first START cycle; ends on the negedge of
   // the cycle after the stop bit.
   task automatic capture_frame(input string tag, input int toggle_at);
      int   len;
      int   dones;
      int   b;
      int   ph;
      logic prev_sclk;
      len       = exp_bits.size() * CLK_DIV;
      dones     = 0;
      prev_sclk = 1'b1;
      dec_bits.delete();
      for (int c = 0; c < len; c++) begin
         b  = c / CLK_DIV;
         ph = c % CLK_DIV;
         check({tag, "_tx"},   32'(o_Tx),   32'(exp_bits[b]));
         check({tag, "_sclk"}, 32'(o_Sclk), 32'(ph >= CLK_DIV / 2));
         check({tag, "_busy"}, 32'(o_Busy), 32'(1));
         check({tag, "_done"}, 32'(o_Done), 32'(c == len - 1));
`ifndef USRT_TX_FIFO_EN
         check({tag, "_ready"}, 32'(o_Ready), 32'(0));
`endif
         if (o_Done) dones++;
         if (!prev_sclk && o_Sclk) dec_bits.push_back(o_Tx);
         prev_sclk = o_Sclk;
         if (c == toggle_at) i_Parity = ~i_Parity;
         @(negedge i_Pclk);
      end
      check({tag, "_done_count"}, 32'(dones), 32'(1));
      check({tag, "_dec_len"},    32'(dec_bits.size()), 32'(exp_bits.size()));
      check({tag, "_dec_frame"},  pack_bits(dec_bits), pack_bits(exp_bits));
   endtask

   // Called on a negedge with the line idle; returns on a negedge.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] p,
                             input string tag, input int toggle_at);
      int n;
      n = 0;
      build_expected(d, p);
      i_Data   = d;
      i_Parity = p;
      i_Valid  = 1'b1;
      while (!o_Ready && n < 200) begin
         @(negedge i_Pclk);
         n++;
      end
      check({tag, "_accept"}, 32'(o_Ready), 32'(1));
      @(negedge i_Pclk);
      i_Valid = 1'b0;
      i_Data  = 8'($urandom);
      if (toggle_at < 0) i_Parity = 2'($urandom);
      repeat (START_LAT - 1) @(negedge i_Pclk);
      capture_frame(tag, toggle_at);
      check({tag, "_idle_busy"},  32'(o_Busy),  32'(0));
      check({tag, "_idle_tx"},    32'(o_Tx),    32'(1));
      check({tag, "_idle_sclk"},  32'(o_Sclk),  32'(1));
      check({tag, "_idle_ready"}, 32'(o_Ready), 32'(1));
      check({tag, "_idle_level"}, 32'(o_Level), 32'(0));
   endtask

`ifdef USRT_TX_FIFO_EN
   logic [7:0] fifo_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
`endif

   initial begin
      i_Rst    = 1'b1;
      i_Valid  = 1'b0;
      i_Data   = '0;
      i_Parity = '0;

      // Reset state
      #3;
      check("rst_tx",    32'(o_Tx),    32'(1));
      check("rst_sclk",  32'(o_Sclk),  32'(1));
      check("rst_busy",  32'(o_Busy),  32'(0));
      check("rst_done",  32'(o_Done),  32'(0));
      check("rst_level", 32'(o_Level), 32'(0));
      @(negedge i_Pclk);
      @(negedge i_Pclk);
      i_Rst = 1'b0;
      @(negedge i_Pclk);
      check("post_rst_ready", 32'(o_Ready), 32'(1));
      check("post_rst_busy",  32'(o_Busy),  32'(0));

      // 0xA5 even: 0,1,0,1,0,0,1,0,1,0,1
      send_frame(8'hA5, 2'b01, "t1_a5_even", -1);
      check("t1_frame", pack_bits(dec_bits), 32'h54A);
      check("t1_len",   32'(dec_bits.size()), 32'd11);

      // Odd parity on rising-edge samples
      send_frame(8'h07, 2'b10, "t2_07_odd", -1);
      check("t2_07_par", 32'(dec_bits[9]), 32'(0));
      send_frame(8'h06, 2'b10, "t2_06_odd", -1);
      check("t2_06_par", 32'(dec_bits[9]), 32'(1));

      // No parity: 0,0,1,0,1,1,0,1,0,1
      send_frame(8'h5A, 2'b00, "t3_5a_none", -1);
      check("t3_frame", pack_bits(dec_bits), 32'h2B4);
      check("t3_len",   32'(dec_bits.size()), 32'd10);

      // Mode 11 also means none
      send_frame(8'hC3, 2'b11, "t3_c3_11", -1);
      check("t3_11_len", 32'(dec_bits.size()), 32'd10);

      // Parity mode toggled mid-frame must not affect the frame in flight
      send_frame(8'h3C, 2'b01, "t6_toggle", 5 * CLK_DIV);
      check("t6_par", 32'(dec_bits[9]), 32'(0));

      // Reset during data bit 3 of 0xFF
      i_Data   = 8'hFF;
      i_Parity = 2'b01;
      i_Valid  = 1'b1;
      @(negedge i_Pclk);
      i_Valid = 1'b0;
      repeat (START_LAT - 1) @(negedge i_Pclk);
      repeat (4 * CLK_DIV + 1) @(negedge i_Pclk);
      check("t5_pre_busy", 32'(o_Busy), 32'(1));
      check("t5_pre_sclk", 32'(o_Sclk), 32'(0));
      #2;
      i_Rst = 1'b1;
      #1;
      check("t5_rst_tx",    32'(o_Tx),    32'(1));
      check("t5_rst_sclk",  32'(o_Sclk),  32'(1));
      check("t5_rst_busy",  32'(o_Busy),  32'(0));
      check("t5_rst_done",  32'(o_Done),  32'(0));
      check("t5_rst_level", 32'(o_Level), 32'(0));
      @(negedge i_Pclk);
      i_Rst = 1'b0;
      @(negedge i_Pclk);
      check("t5_rel_ready", 32'(o_Ready), 32'(1));
      check("t5_rel_busy",  32'(o_Busy),  32'(0));
      send_frame(8'h00, 2'b01, "t5_after_rst", -1);
      check("t5_par", 32'(dec_bits[9]), 32'(0));

      // Randomized frames with random idle gaps
      for (int k = 0; k < 20; k++) begin
         send_frame(8'($urandom), 2'($urandom), "rand", -1);
         repeat ($urandom_range(0, 3)) @(negedge i_Pclk);
      end

`ifdef USRT_TX_FIFO_EN
      // Queue fills while the first frame is on the line, then drains back-to-back
      i_Data   = fifo_bytes[0];
      i_Parity = 2'b01;
      i_Valid  = 1'b1;
      check("t4_ready0", 32'(o_Ready), 32'(1));
      @(negedge i_Pclk);
      i_Valid = 1'b0;
      check("t4_level_first", 32'(o_Level), 32'(1));
      @(negedge i_Pclk);
      check("t4_level_popped", 32'(o_Level), 32'(0));
      build_expected(fifo_bytes[0], 2'b01);
      fork
         capture_frame("t4_f0", -1);
         begin
            for (int k = 0; k < 4; k++) begin
               check("t4_push_ready", 32'(o_Ready), 32'(1));
               check("t4_push_level", 32'(o_Level), 32'(k));
               i_Data   = fifo_bytes[k+1];
               i_Parity = 2'b01;
               i_Valid  = 1'b1;
               @(negedge i_Pclk);
            end
            i_Data = 8'hEE;
            for (int k = 0; k < 3; k++) begin
               check("t4_full_level", 32'(o_Level), 32'(4));
               check("t4_full_ready", 32'(o_Ready), 32'(0));
               @(negedge i_Pclk);
            end
            i_Valid = 1'b0;
         end
      join
      for (int k = 1; k < 5; k++) begin
         check("t4_level_drain", 32'(o_Level), 32'(4 - k));
         build_expected(fifo_bytes[k], 2'b01);
         capture_frame("t4_fn", -1);
      end
      check("t4_end_busy",  32'(o_Busy),  32'(0));
      check("t4_end_level", 32'(o_Level), 32'(0));
      check("t4_end_ready", 32'(o_Ready), 32'(1));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
